// File: rtl/instruction_fetch_prefetcher_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_prefetcher_pkg
// Shared constants and helpers for the fetch front end and its prefetch FIFO.
// Holds the default bus widths, the PC increment (bytes per instruction), the
// default reset PC and the log2 helper used to size pointers and counters.
// ---------------------------------------------------------------------------
package instruction_fetch_prefetcher_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 32;
    localparam int DEFAULT_ADDRESS_BITS = 32;

    // Bytes per instruction word; this is the sequential PC increment.
    function automatic int numBytes(input int dataWidth);
        return dataWidth / 8;
    endfunction

    localparam int          NUM_BYTES        = numBytes(DEFAULT_DATA_WIDTH);
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Ceiling log2, valid for value >= 1.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/instruction_fetch_prefetcher_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_prefetcher_if
// Bundles the memory instruction-port signals, the redirect request and the
// decode handshake of the fetch front end.
//   master : the prefetcher (drives mem_read/mem_address and inst_* outputs)
//   slave  : the environment (memory port, redirect source and decode)
// Signals:
//   mem_read, mem_address            request to the instruction port
//   mem_data, mem_address_returned,
//   mem_valid, mem_ready             response and availability from memory
//   redirect, redirect_pc            flush and restart fetch at a new PC
//   inst_valid, inst, inst_pc        FIFO head presented to decode
//   inst_ready                       decode accepts the head
// ---------------------------------------------------------------------------
interface instruction_fetch_prefetcher_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32
) ();

    logic                    mem_read;
    logic [ADDRESS_BITS-1:0] mem_address;
    logic [DATA_WIDTH-1:0]   mem_data;
    logic [ADDRESS_BITS-1:0] mem_address_returned;
    logic                    mem_valid;
    logic                    mem_ready;
    logic                    redirect;
    logic [ADDRESS_BITS-1:0] redirect_pc;
    logic                    inst_valid;
    logic [DATA_WIDTH-1:0]   inst;
    logic [ADDRESS_BITS-1:0] inst_pc;
    logic                    inst_ready;

    modport master (
        output mem_read, mem_address,
        input  mem_data, mem_address_returned, mem_valid, mem_ready,
        input  redirect, redirect_pc,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  mem_read, mem_address,
        output mem_data, mem_address_returned, mem_valid, mem_ready,
        output redirect, redirect_pc,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/instruction_fetch_prefetcher_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding {instruction, pc} pairs for decode.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   i_flush     synchronous flush, wins over push and pop
//   i_push      write i_data at the tail
//   i_data      entry to write
//   i_pop       drop the head entry
//   o_data      head entry, zero while the FIFO is empty
//   o_count     number of valid entries
// DEPTH must be a power of two; pointers wrap by masking.
// ---------------------------------------------------------------------------
module fetch_fifo
    import instruction_fetch_prefetcher_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic [log2(DEPTH):0]   o_count
);

    localparam int             PTR_W    = log2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_entries [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;

    // Storage, pointers and occupancy. A simultaneous push and pop leaves the
    // count unchanged, which is what lets a full FIFO accept a push while its
    // head is being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_entries[r_wrPtr] <= i_data;
                r_wrPtr            <= (r_wrPtr + PTR_W'(1)) & PTR_MASK;
            end
            if (i_pop) begin
                r_rdPtr <= (r_rdPtr + PTR_W'(1)) & PTR_MASK;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + (PTR_W + 1)'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - (PTR_W + 1)'(1);
            end
        end
    end

    // Empty FIFO presents zeros instead of stale entries.
    assign o_data  = (r_count != '0) ? r_entries[r_rdPtr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_prefetcher.sv
// ---------------------------------------------------------------------------
// instruction_fetch_prefetcher
// Fetch front end ahead of the BRAM instruction port. Generates sequential
// fetch addresses, issues one-cycle-latency reads, buffers the responses in a
// prefetch FIFO and hands them to decode over a valid/ready handshake.
// A redirect flushes buffered and in-flight instructions and restarts fetch.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-low
//   bus    instruction_fetch_prefetcher_if master modport (memory request and
//          response, redirect, decode handshake)
// ---------------------------------------------------------------------------
module instruction_fetch_prefetcher
    import instruction_fetch_prefetcher_pkg::*;
#(
    parameter int                      DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int                      ADDRESS_BITS = DEFAULT_ADDRESS_BITS,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = ADDRESS_BITS'(RESET_PC_DEFAULT),
    parameter int                      FIFO_DEPTH   = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    instruction_fetch_prefetcher_if.master bus
);

    localparam int PC_STEP = numBytes(DATA_WIDTH);
    localparam int COUNT_W = log2(FIFO_DEPTH) + 1;
    localparam int OCC_W   = COUNT_W + 2;
    localparam int ENTRY_W = DATA_WIDTH + ADDRESS_BITS;

    logic                    r_memRead;
    logic [ADDRESS_BITS-1:0] r_memAddress;
    logic [ADDRESS_BITS-1:0] r_fetchPc;
    logic                    r_discard;

    logic                    w_acceptNow;
    logic                    w_pop;
    logic                    w_issue;
    logic [OCC_W-1:0]        w_occupancy;
    logic [ADDRESS_BITS-1:0] w_alignedRedirectPc;
    logic [COUNT_W-1:0]      w_count;
    logic [ENTRY_W-1:0]      w_head;

    // Issue/accept decisions. The occupancy bound counts the response being
    // accepted now and the request already outstanding, and deliberately
    // ignores a same-cycle pop, so an accepted response always finds room.
    always_comb begin
        w_acceptNow         = bus.mem_valid && !r_discard && !bus.redirect;
        w_pop               = (w_count != '0) && bus.inst_ready && !bus.redirect;
        w_occupancy         = OCC_W'(w_count) + OCC_W'(w_acceptNow)
                            + OCC_W'(r_memRead) + OCC_W'(1);
        w_issue             = !bus.redirect && bus.mem_ready
                            && (w_occupancy <= OCC_W'(FIFO_DEPTH));
        w_alignedRedirectPc = bus.redirect_pc & ~ADDRESS_BITS'(PC_STEP - 1);
    end

    // Request registers, fetch PC and the discard flag. On redirect the
    // outstanding request (if any) is marked for discard so its response,
    // arriving next cycle, never reaches the FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_memRead    <= 1'b0;
            r_memAddress <= RESET_PC;
            r_fetchPc    <= RESET_PC;
            r_discard    <= 1'b0;
        end else begin
            r_memRead <= w_issue;
            r_discard <= bus.redirect && r_memRead;
            if (bus.redirect) begin
                r_fetchPc <= w_alignedRedirectPc;
            end else if (w_issue) begin
                r_memAddress <= r_fetchPc;
                r_fetchPc    <= r_fetchPc + ADDRESS_BITS'(PC_STEP);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fetchFifo (
        .clk     (clock),
        .rst_n   (reset),
        .i_flush (bus.redirect),
        .i_push  (w_acceptNow),
        .i_data  ({bus.mem_data, bus.mem_address_returned}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign bus.mem_read    = r_memRead;
    assign bus.mem_address = r_memAddress;
    assign bus.inst_valid  = (w_count != '0);
    assign bus.inst        = w_head[ENTRY_W-1 -: DATA_WIDTH];
    assign bus.inst_pc     = w_head[ADDRESS_BITS-1:0];

endmodule

// File: tb/tb_instruction_fetch_prefetcher.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_prefetcher
// Directed and randomized bench for instruction_fetch_prefetcher. The memory
// is a one-cycle-latency responder; the reference is the architectural
// instruction stream: every instruction decode accepts must carry the next
// expected PC and the memory word at that PC, with redirects and reset
// restarting the stream.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_prefetcher;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock;
    logic        reset;
    int          total;
    int          bad;
    int          delivered;
    int          startDelivered;
    logic        reqValid;
    logic [31:0] reqAddr;
    logic        scramble;
    logic [31:0] expectedPc;
    logic        rReady;
    logic        rMemReady;
    logic        rRedirect;

    instruction_fetch_prefetcher_if #(.DATA_WIDTH(32), .ADDRESS_BITS(32)) bus ();

    instruction_fetch_prefetcher #(
        .DATA_WIDTH   (32),
        .ADDRESS_BITS (32),
        .RESET_PC     (RESET_PC),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents: the address itself, or a scrambled form of it so that
    // instruction and PC cannot be confused.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return scramble ? (a ^ 32'h5A5A_C3C3) : a;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic memReady,
                                 input logic redir, input logic [31:0] pc);
        bus.inst_ready  = ready;
        bus.mem_ready   = memReady;
        bus.redirect    = redir;
        bus.redirect_pc = pc;
    endtask

    // Ends the current cycle: the memory latches this cycle's request and
    // answers it during the next cycle; without a request it drives junk.
    task automatic advanceCycle();
        reqValid = bus.mem_read;
        reqAddr  = bus.mem_address;
        @(posedge clock);
        #1;
        bus.mem_valid = reqValid;
        if (reqValid) begin
            bus.mem_address_returned = reqAddr;
            bus.mem_data             = memWord(reqAddr);
        end else begin
            bus.mem_address_returned = $urandom();
            bus.mem_data             = $urandom();
        end
    endtask

    // Stream model: a redirect restarts the stream at the aligned PC, an
    // accepted instruction must be the next one in program order.
    task automatic checkCycle(input logic strict);
        if (strict) begin
            checkOutput("stream_valid", {63'd0, bus.inst_valid}, 64'd1);
        end
        if (bus.redirect) begin
            expectedPc = bus.redirect_pc & 32'hFFFF_FFFC;
        end else if (bus.inst_valid && bus.inst_ready) begin
            checkOutput("pop_pc", {32'd0, bus.inst_pc}, {32'd0, expectedPc});
            checkOutput("pop_inst", {32'd0, bus.inst}, {32'd0, memWord(expectedPc)});
            expectedPc = expectedPc + 32'd4;
            delivered++;
        end
    endtask

    task automatic runCycles(input int n, input logic ready, input logic memReady,
                             input logic strict);
        for (int i = 0; i < n; i++) begin
            applyStimulus(ready, memReady, 1'b0, 32'd0);
            checkCycle(strict);
            advanceCycle();
        end
    endtask

    task automatic waitForValid(input string tag);
        for (int i = 0; i < 8 && !bus.inst_valid; i++) begin
            checkCycle(1'b0);
            advanceCycle();
        end
        checkOutput(tag, {63'd0, bus.inst_valid}, 64'd1);
    endtask

    task automatic redirectTo(input logic [31:0] pc, input string tag,
                              input logic [31:0] firstPc);
        applyStimulus(1'b1, 1'b1, 1'b1, pc);
        checkCycle(1'b0);
        advanceCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        waitForValid({tag, "_restart"});
        checkOutput({tag, "_first_pc"}, {32'd0, bus.inst_pc}, {32'd0, firstPc});
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_inst_valid"}, {63'd0, bus.inst_valid}, 64'd0);
        checkOutput({tag, "_inst"}, {32'd0, bus.inst}, 64'd0);
        checkOutput({tag, "_inst_pc"}, {32'd0, bus.inst_pc}, 64'd0);
        checkOutput({tag, "_mem_read"}, {63'd0, bus.mem_read}, 64'd0);
        checkOutput({tag, "_mem_address"}, {32'd0, bus.mem_address}, {32'd0, RESET_PC});
    endtask

    task automatic checkStartup(input string tag);
        checkOutput({tag, "_c0_mem_read"}, {63'd0, bus.mem_read}, 64'd0);
        advanceCycle();
        checkOutput({tag, "_c1_mem_read"}, {63'd0, bus.mem_read}, 64'd1);
        checkOutput({tag, "_c1_mem_address"}, {32'd0, bus.mem_address}, {32'd0, RESET_PC});
        checkOutput({tag, "_c1_inst_valid"}, {63'd0, bus.inst_valid}, 64'd0);
        advanceCycle();
        checkOutput({tag, "_c2_inst_valid"}, {63'd0, bus.inst_valid}, 64'd0);
        advanceCycle();
        checkOutput({tag, "_c3_inst_valid"}, {63'd0, bus.inst_valid}, 64'd1);
        checkOutput({tag, "_c3_inst_pc"}, {32'd0, bus.inst_pc}, {32'd0, RESET_PC});
        checkOutput({tag, "_c3_inst"}, {32'd0, bus.inst}, {32'd0, memWord(RESET_PC)});
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        delivered  = 0;
        scramble   = 1'b0;
        expectedPc = RESET_PC;
        reqValid   = 1'b0;
        reqAddr    = 32'd0;
        reset      = 1'b0;
        bus.mem_valid            = 1'b0;
        bus.mem_data             = 32'd0;
        bus.mem_address_returned = 32'd0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        checkResetOutputs("reset");

        // Release reset; this is cycle 0, the next edge issues RESET_PC.
        reset = 1'b1;
        checkStartup("startup");
        runCycles(12, 1'b1, 1'b1, 1'b1);

        // Decode stall: the prefetcher fills up and stops requesting.
        runCycles(20, 1'b0, 1'b1, 1'b0);
        checkOutput("stall_mem_read", {63'd0, bus.mem_read}, 64'd0);
        checkOutput("stall_inst_valid", {63'd0, bus.inst_valid}, 64'd1);
        runCycles(10, 1'b1, 1'b1, 1'b1);

        // Redirect with entries buffered and a request in flight.
        runCycles(1, 1'b0, 1'b1, 1'b0);
        checkOutput("inflight_at_redirect", {63'd0, bus.mem_read}, 64'd1);
        checkOutput("buffered_at_redirect", {63'd0, bus.inst_valid}, 64'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        checkCycle(1'b0);
        advanceCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("redirect_gap1_valid", {63'd0, bus.inst_valid}, 64'd0);
        checkCycle(1'b0);
        advanceCycle();
        checkOutput("redirect_gap2_valid", {63'd0, bus.inst_valid}, 64'd0);
        checkCycle(1'b0);
        advanceCycle();
        waitForValid("redirect_restart");
        checkOutput("redirect_first_pc", {32'd0, bus.inst_pc}, 64'h100);
        runCycles(6, 1'b1, 1'b1, 1'b1);

        // Back-to-back redirects: the later target wins.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        checkCycle(1'b0);
        advanceCycle();
        redirectTo(32'h0000_0300, "b2b", 32'h0000_0300);
        runCycles(4, 1'b1, 1'b1, 1'b1);

        // Misaligned target is aligned down; PC wraps at the top of memory.
        redirectTo(32'h0000_0103, "align", 32'h0000_0100);
        runCycles(4, 1'b1, 1'b1, 1'b1);
        redirectTo(32'hFFFF_FFFC, "wrap", 32'hFFFF_FFFC);
        runCycles(1, 1'b1, 1'b1, 1'b1);
        checkOutput("wrap_next_pc", {32'd0, bus.inst_pc}, 64'd0);
        runCycles(4, 1'b1, 1'b1, 1'b1);

        // Random decode readiness, memory availability and redirects.
        startDelivered = delivered;
        for (int i = 0; i < 300; i++) begin
            rReady    = ($urandom_range(0, 3) != 0);
            rMemReady = ($urandom_range(0, 4) != 0);
            rRedirect = ($urandom_range(0, 15) == 0);
            applyStimulus(rReady, rMemReady, rRedirect, $urandom());
            checkCycle(1'b0);
            advanceCycle();
            if (!rMemReady || rRedirect) begin
                checkOutput("issue_blocked", {63'd0, bus.mem_read}, 64'd0);
            end
        end
        checkOutput("random_progress",
                    {63'd0, (delivered - startDelivered) > 40}, 64'd1);

        // Asynchronous reset in mid-stream with entries buffered.
        runCycles(4, 1'b1, 1'b1, 1'b0);
        runCycles(3, 1'b0, 1'b1, 1'b0);
        checkOutput("pre_reset_valid", {63'd0, bus.inst_valid}, 64'd1);
        reset = 1'b0;
        #1;
        checkResetOutputs("midreset");
        scramble = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        bus.mem_valid = 1'b0;
        expectedPc    = RESET_PC;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        reset = 1'b1;
        checkStartup("restart");
        runCycles(8, 1'b1, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
